// File: rtl/axi_register_slice_if.sv
// AXI4 five-channel bundle (AW, W, B, AR, R) carried between slice ports.
// master: drives AW/W/AR payload+valid and B/R ready; slave: the reverse.
interface axi_register_slice_if #(
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH  = 1,
    parameter int ARUSER_WIDTH = 1,
    parameter int RUSER_WIDTH  = 1
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic [AWUSER_WIDTH-1:0] awuser;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [STRB_WIDTH-1:0]   wstrb;
    logic                    wlast;
    logic [WUSER_WIDTH-1:0]  wuser;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic [BUSER_WIDTH-1:0]  buser;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic [ARUSER_WIDTH-1:0] aruser;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [RUSER_WIDTH-1:0]  ruser;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock,
        output awcache, awprot, awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock,
        output arcache, arprot, arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock,
        input  awcache, awprot, awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock,
        input  arcache, arprot, arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_register_slice.sv
// AXI4 register slice: per-channel bypass / forward register / skid buffer.
// Ports: clk, rst (async, active-low), s_axi (slave side), m_axi (master side).
module axi_slice_stage #(
    parameter int WIDTH = 1,
    parameter int MODE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
    output logic             up_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic             dn_valid,
    input  logic             dn_ready
);
    if (MODE == 0) begin : g_bypass
        logic unused_clk;
        assign unused_clk = clk;
        assign dn_data    = up_data;
        // Reset masks the pass-through handshake so no beat moves.
        assign dn_valid   = up_valid && rst;
        assign up_ready   = dn_ready && rst;
    end else if (MODE == 1) begin : g_fwd
        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        assign up_ready = !valid_q || dn_ready;
        assign dn_valid = valid_q;
        assign dn_data  = data_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (up_valid && up_ready) begin
                valid_q <= 1'b1;
                data_q  <= up_data;
            end else if (dn_ready) begin
                valid_q <= 1'b0;
            end
        end
    end else if (MODE == 2) begin : g_skid
        typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

        state_t           state_q, state_d;
        logic             ready_q;
        logic [WIDTH-1:0] main_q, skid_q;
        logic             load_main, load_skid, main_from_skid;
        logic             accept, take;

        assign dn_valid = (state_q != EMPTY);
        assign dn_data  = main_q;
        assign up_ready = ready_q;
        assign accept   = up_valid && ready_q;
        assign take     = dn_valid && dn_ready;

        always_comb begin
            state_d        = state_q;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (take) begin
                        state_d        = ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // ready is a flop: it only drops while the skid holds a beat.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= EMPTY;
                ready_q <= 1'b0;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                state_q <= state_d;
                ready_q <= (state_d != TWO);
                if (load_main) begin
                    main_q <= up_data;
                end else if (main_from_skid) begin
                    main_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= up_data;
                end
            end
        end
    end else begin : g_bad_mode
        $error("axi_slice_stage: MODE must be 0, 1 or 2");
    end
endmodule

module axi_register_slice #(
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH  = 1,
    parameter int ARUSER_WIDTH = 1,
    parameter int RUSER_WIDTH  = 1,
    parameter int AW_MODE      = 2,
    parameter int W_MODE       = 2,
    parameter int B_MODE       = 2,
    parameter int AR_MODE      = 2,
    parameter int R_MODE       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_register_slice_if.slave  s_axi,
    axi_register_slice_if.master m_axi
);
    // len+size+burst+lock+cache+prot+qos+region
    localparam int AX_W = 29;
    localparam int AW_W = ID_WIDTH + ADDR_WIDTH + AX_W + AWUSER_WIDTH;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1 + WUSER_WIDTH;
    localparam int B_W  = ID_WIDTH + 2 + BUSER_WIDTH;
    localparam int AR_W = ID_WIDTH + ADDR_WIDTH + AX_W + ARUSER_WIDTH;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3 + RUSER_WIDTH;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data
        $error("axi_register_slice: DATA_WIDTH must be a multiple of 8");
    end

    logic [AW_W-1:0] aw_up, aw_dn;
    logic [W_W-1:0]  w_up, w_dn;
    logic [B_W-1:0]  b_up, b_dn;
    logic [AR_W-1:0] ar_up, ar_dn;
    logic [R_W-1:0]  r_up, r_dn;

    assign aw_up = {s_axi.awid, s_axi.awaddr, s_axi.awlen,
                    s_axi.awsize, s_axi.awburst, s_axi.awlock,
                    s_axi.awcache, s_axi.awprot, s_axi.awqos,
                    s_axi.awregion, s_axi.awuser};
    assign {m_axi.awid, m_axi.awaddr, m_axi.awlen,
            m_axi.awsize, m_axi.awburst, m_axi.awlock,
            m_axi.awcache, m_axi.awprot, m_axi.awqos,
            m_axi.awregion, m_axi.awuser} = aw_dn;

    assign w_up = {s_axi.wdata, s_axi.wstrb,
                   s_axi.wlast, s_axi.wuser};
    assign {m_axi.wdata, m_axi.wstrb,
            m_axi.wlast, m_axi.wuser} = w_dn;

    assign b_up = {m_axi.bid, m_axi.bresp, m_axi.buser};
    assign {s_axi.bid, s_axi.bresp, s_axi.buser} = b_dn;

    assign ar_up = {s_axi.arid, s_axi.araddr, s_axi.arlen,
                    s_axi.arsize, s_axi.arburst, s_axi.arlock,
                    s_axi.arcache, s_axi.arprot, s_axi.arqos,
                    s_axi.arregion, s_axi.aruser};
    assign {m_axi.arid, m_axi.araddr, m_axi.arlen,
            m_axi.arsize, m_axi.arburst, m_axi.arlock,
            m_axi.arcache, m_axi.arprot, m_axi.arqos,
            m_axi.arregion, m_axi.aruser} = ar_dn;

    assign r_up = {m_axi.rid, m_axi.rdata, m_axi.rresp,
                   m_axi.rlast, m_axi.ruser};
    assign {s_axi.rid, s_axi.rdata, s_axi.rresp,
            s_axi.rlast, s_axi.ruser} = r_dn;

    axi_slice_stage #(.WIDTH(AW_W), .MODE(AW_MODE)) u_aw (
        .clk      (clk),
        .rst      (rst),
        .up_data  (aw_up),
        .up_valid (s_axi.awvalid),
        .up_ready (s_axi.awready),
        .dn_data  (aw_dn),
        .dn_valid (m_axi.awvalid),
        .dn_ready (m_axi.awready)
    );

    axi_slice_stage #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
        .clk      (clk),
        .rst      (rst),
        .up_data  (w_up),
        .up_valid (s_axi.wvalid),
        .up_ready (s_axi.wready),
        .dn_data  (w_dn),
        .dn_valid (m_axi.wvalid),
        .dn_ready (m_axi.wready)
    );

    axi_slice_stage #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
        .clk      (clk),
        .rst      (rst),
        .up_data  (b_up),
        .up_valid (m_axi.bvalid),
        .up_ready (m_axi.bready),
        .dn_data  (b_dn),
        .dn_valid (s_axi.bvalid),
        .dn_ready (s_axi.bready)
    );

    axi_slice_stage #(.WIDTH(AR_W), .MODE(AR_MODE)) u_ar (
        .clk      (clk),
        .rst      (rst),
        .up_data  (ar_up),
        .up_valid (s_axi.arvalid),
        .up_ready (s_axi.arready),
        .dn_data  (ar_dn),
        .dn_valid (m_axi.arvalid),
        .dn_ready (m_axi.arready)
    );

    axi_slice_stage #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
        .clk      (clk),
        .rst      (rst),
        .up_data  (r_up),
        .up_valid (m_axi.rvalid),
        .up_ready (m_axi.rready),
        .dn_data  (r_dn),
        .dn_valid (s_axi.rvalid),
        .dn_ready (s_axi.rready)
    );
endmodule

// File: tb/tb_axi_register_slice.sv
// Bench for axi_register_slice: AW/W/AR skid, B bypass, R forward register.
// Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R.
module tb_axi_register_slice;
    localparam int PW = 66;
    typedef logic [PW-1:0] pl_t;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        dr;
        logic        exp_rdy;
        logic        exp_v;
        logic [31:0] exp_a;
    } ar_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_register_slice_if s_if ();
    axi_register_slice_if m_if ();

    axi_register_slice #(
        .AW_MODE (2),
        .W_MODE  (2),
        .B_MODE  (0),
        .AR_MODE (2),
        .R_MODE  (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (s_if),
        .m_axi (m_if)
    );

    logic [4:0] drv_v  = '0;
    logic [4:0] drv_dr = '0;
    pl_t        drv_p [5];
    logic [4:0] up_r, dn_v;
    pl_t        up_p [5];
    pl_t        dn_p [5];

    assign {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize,
            s_if.awburst, s_if.awlock, s_if.awcache, s_if.awprot,
            s_if.awqos, s_if.awregion, s_if.awuser} = drv_p[0];
    assign {s_if.wdata, s_if.wstrb, s_if.wlast,
            s_if.wuser} = drv_p[1][37:0];
    assign {m_if.bid, m_if.bresp, m_if.buser} = drv_p[2][6:0];
    assign {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize,
            s_if.arburst, s_if.arlock, s_if.arcache, s_if.arprot,
            s_if.arqos, s_if.arregion, s_if.aruser} = drv_p[3];
    assign {m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast,
            m_if.ruser} = drv_p[4][39:0];

    assign s_if.awvalid = drv_v[0];
    assign s_if.wvalid  = drv_v[1];
    assign m_if.bvalid  = drv_v[2];
    assign s_if.arvalid = drv_v[3];
    assign m_if.rvalid  = drv_v[4];
    assign m_if.awready = drv_dr[0];
    assign m_if.wready  = drv_dr[1];
    assign s_if.bready  = drv_dr[2];
    assign m_if.arready = drv_dr[3];
    assign s_if.rready  = drv_dr[4];

    assign up_r = {m_if.rready, s_if.arready, m_if.bready,
                   s_if.wready, s_if.awready};
    assign dn_v = {s_if.rvalid, m_if.arvalid, s_if.bvalid,
                   m_if.wvalid, m_if.awvalid};

    assign up_p[0] = pl_t'({s_if.awid, s_if.awaddr, s_if.awlen,
        s_if.awsize, s_if.awburst, s_if.awlock, s_if.awcache,
        s_if.awprot, s_if.awqos, s_if.awregion, s_if.awuser});
    assign up_p[1] = pl_t'({s_if.wdata, s_if.wstrb, s_if.wlast,
        s_if.wuser});
    assign up_p[2] = pl_t'({m_if.bid, m_if.bresp, m_if.buser});
    assign up_p[3] = pl_t'({s_if.arid, s_if.araddr, s_if.arlen,
        s_if.arsize, s_if.arburst, s_if.arlock, s_if.arcache,
        s_if.arprot, s_if.arqos, s_if.arregion, s_if.aruser});
    assign up_p[4] = pl_t'({m_if.rid, m_if.rdata, m_if.rresp,
        m_if.rlast, m_if.ruser});

    assign dn_p[0] = pl_t'({m_if.awid, m_if.awaddr, m_if.awlen,
        m_if.awsize, m_if.awburst, m_if.awlock, m_if.awcache,
        m_if.awprot, m_if.awqos, m_if.awregion, m_if.awuser});
    assign dn_p[1] = pl_t'({m_if.wdata, m_if.wstrb, m_if.wlast,
        m_if.wuser});
    assign dn_p[2] = pl_t'({s_if.bid, s_if.bresp, s_if.buser});
    assign dn_p[3] = pl_t'({m_if.arid, m_if.araddr, m_if.arlen,
        m_if.arsize, m_if.arburst, m_if.arlock, m_if.arcache,
        m_if.arprot, m_if.arqos, m_if.arregion, m_if.aruser});
    assign dn_p[4] = pl_t'({s_if.rid, s_if.rdata, s_if.rresp,
        s_if.rlast, s_if.ruser});

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input pl_t got,
                       input pl_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic pl_t rnd();
        return pl_t'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic pl_t mk_ar(input logic [31:0] a);
        return {4'd0, a, 30'd0};
    endfunction

    // Scoreboard: upstream handshakes push, downstream ones pop.
    pl_t        sbq [5][$];
    logic [4:0] hs_up   = '0;
    logic [4:0] stall_q = '0;
    pl_t        stall_p [5];

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 5; c++) sbq[c].delete();
            hs_up   = '0;
            stall_q = '0;
        end else begin
            for (int c = 0; c < 5; c++) begin
                if (stall_q[c]) begin
                    chk($sformatf("stable_v_ch%0d", c),
                        pl_t'(dn_v[c]), pl_t'(1));
                    chk($sformatf("stable_p_ch%0d", c),
                        dn_p[c], stall_p[c]);
                end
                hs_up[c] = drv_v[c] && up_r[c];
                if (hs_up[c]) sbq[c].push_back(up_p[c]);
                if (dn_v[c] && drv_dr[c]) begin
                    if (sbq[c].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_beat_ch%0d: got %h expected none",
                                 c, dn_p[c]);
                    end else begin
                        chk($sformatf("order_ch%0d", c), dn_p[c],
                            sbq[c].pop_front());
                    end
                end
                stall_q[c] = dn_v[c] && !drv_dr[c];
                stall_p[c] = dn_p[c];
            end
        end
    end

    ar_vec_t     tv [8];
    int          sent;
    logic        prev_hs;
    logic [31:0] prev_d;

    initial begin
        tv[0] = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0};
        tv[1] = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h100};
        tv[2] = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100};
        tv[3] = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100};
        tv[4] = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h100};
        tv[5] = '{1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 32'h104};
        tv[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h108};
        tv[7] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0};
        for (int c = 0; c < 5; c++) drv_p[c] = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drv_v  = 5'($urandom());
            drv_dr = 5'($urandom());
            for (int c = 0; c < 5; c++) drv_p[c] = rnd();
            @(negedge clk);
            chk("rst_valids", pl_t'(dn_v), pl_t'(0));
            chk("rst_skid_ready", pl_t'({s_if.arready,
                s_if.wready, s_if.awready}), pl_t'(0));
            chk("rst_fwd_ready", pl_t'(m_if.rready), pl_t'(1));
            chk("rst_payload", dn_p[0] | dn_p[1] | dn_p[3] | dn_p[4],
                pl_t'(0));
        end
        @(posedge clk); #1;
        drv_v  = '0;
        drv_dr = '0;
        for (int c = 0; c < 5; c++) drv_p[c] = '0;
        @(negedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_awready", pl_t'(s_if.awready), pl_t'(1));

        // AR backpressure table.
        for (int i = 0; i < 8; i++) begin
            drv_v[3]  = tv[i].v;
            drv_p[3]  = mk_ar(tv[i].a);
            drv_dr[3] = tv[i].dr;
            @(negedge clk);
            chk($sformatf("ar_ready_%0d", i),
                pl_t'(s_if.arready), pl_t'(tv[i].exp_rdy));
            chk($sformatf("ar_valid_%0d", i),
                pl_t'(m_if.arvalid), pl_t'(tv[i].exp_v));
            if (tv[i].exp_v)
                chk($sformatf("ar_addr_%0d", i),
                    pl_t'(m_if.araddr), pl_t'(tv[i].exp_a));
            @(posedge clk); #1;
        end

        // W streaming, no bubbles, 1-cycle delay.
        drv_dr[1] = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            drv_v[1] = (i < 256);
            drv_p[1] = pl_t'({32'(i), 4'hf, (i % 16 == 15), 1'b0});
            @(negedge clk);
            if (i < 256)
                chk("w_ready", pl_t'(s_if.wready), pl_t'(1));
            if (i > 0) begin
                chk("w_valid", pl_t'(m_if.wvalid), pl_t'(1));
                chk("w_data", pl_t'(m_if.wdata), pl_t'(32'(i - 1)));
                chk("w_last", pl_t'(m_if.wlast),
                    pl_t'((i - 1) % 16 == 15));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("w_drain", pl_t'(m_if.wvalid), pl_t'(0));
        @(posedge clk); #1;
        drv_dr[1] = 1'b0;

        // R forward register, random downstream ready.
        sent    = 0;
        prev_hs = 1'b0;
        prev_d  = '0;
        for (int k = 0; k < 2000 && (sent < 64 || dn_v[4]); k++) begin
            drv_v[4]  = (sent < 64);
            drv_p[4]  = pl_t'({4'd3, 32'h1000 + 32'(sent), 2'b00,
                               (sent == 63), 1'b0});
            drv_dr[4] = 1'($urandom() % 2);
            @(negedge clk);
            if (prev_hs) begin
                chk("r_lat_valid", pl_t'(s_if.rvalid), pl_t'(1));
                chk("r_lat_data", pl_t'(s_if.rdata), pl_t'(prev_d));
            end
            prev_hs = drv_v[4] && m_if.rready;
            prev_d  = 32'h1000 + 32'(sent);
            if (prev_hs) sent++;
            @(posedge clk); #1;
        end
        chk("r_count", pl_t'(sent), pl_t'(64));
        chk("r_drained", pl_t'(dn_v[4]), pl_t'(0));
        drv_v[4]  = 1'b0;
        drv_dr[4] = 1'b0;

        // B bypass: same-cycle response.
        drv_p[2]  = pl_t'({4'd5, 2'b10, 1'b0});
        drv_v[2]  = 1'b1;
        drv_dr[2] = 1'b0;
        #1;
        chk("b_valid", pl_t'(s_if.bvalid), pl_t'(1));
        chk("b_id", pl_t'(s_if.bid), pl_t'(5));
        chk("b_resp", pl_t'(s_if.bresp), pl_t'(2));
        chk("b_ready_low", pl_t'(m_if.bready), pl_t'(0));
        drv_dr[2] = 1'b1;
        #1;
        chk("b_ready_high", pl_t'(m_if.bready), pl_t'(1));
        @(posedge clk); #1;
        drv_v[2]  = 1'b0;
        drv_dr[2] = 1'b0;

        // Mid-burst asynchronous reset with AW slice full.
        drv_v[0] = 1'b1;
        drv_p[0] = rnd();
        @(posedge clk); #1;
        drv_p[0] = rnd();
        @(posedge clk); #1;
        drv_v[0] = 1'b0;
        @(negedge clk);
        chk("aw_full_ready", pl_t'(s_if.awready), pl_t'(0));
        chk("aw_full_valid", pl_t'(m_if.awvalid), pl_t'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", pl_t'(m_if.awvalid), pl_t'(0));
        chk("arst_ready", pl_t'(s_if.awready), pl_t'(0));
        chk("arst_data", dn_p[0], pl_t'(0));
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst = 1'b1;
        drv_dr[0] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", pl_t'(m_if.awvalid), pl_t'(0));
            chk("aw_ready_back", pl_t'(s_if.awready), pl_t'(1));
            @(posedge clk); #1;
        end

        // Random stress on all channels.
        for (int k = 0; k < 10000; k++) begin
            for (int c = 0; c < 5; c++) begin
                if (!drv_v[c] || hs_up[c]) begin
                    drv_v[c] = ($urandom() % 4) != 0;
                    drv_p[c] = rnd();
                end
                drv_dr[c] = ($urandom() % 3) != 0;
            end
            @(posedge clk); #1;
        end
        drv_v  = '0;
        drv_dr = '1;
        repeat (5) @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++)
            chk($sformatf("drain_ch%0d", c),
                pl_t'(sbq[c].size()), pl_t'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
